// File: rtl/zion_riscv_bitops_exec_unit.sv
// rtl/zion_riscv_bitops_exec_unit.sv - RV32/RV64 bitwise logic and iterative count execute unit
//
// Purpose:
//   Ex-stage unit for AND/OR/XOR/ANDN/ORN/XNOR (single cycle) and CLZ/CTZ/CPOP
//   (iterative, STEP bits per cycle). One registered output stage with a
//   valid/ready handshake on both sides.
//
// Ports:
//   iClk    - clock, rising edge
//   iRst_n  - asynchronous active-low reset
//   iFlush  - synchronous abort of the in-flight op and any pending result
//   iValid  - request valid
//   oReady  - unit can accept a request this cycle
//   iOp     - 0 AND,1 OR,2 XOR,3 ANDN,4 ORN,5 XNOR,6 CLZ,7 CTZ,8 CPOP, 9-15 illegal
//   iS1     - source 1 (only source for count ops)
//   iS2     - source 2
//   oValid  - result valid
//   iReady  - consumer accepts result
//   oRslt   - result, count results zero-extended
//   oErr    - illegal opcode flag, qualified by oValid

module zion_riscv_bitops_exec_unit #(
    parameter int RV64 = 0,
    parameter int STEP = 8
) (
    input  logic                               iClk,
    input  logic                               iRst_n,
    input  logic                               iFlush,
    input  logic                               iValid,
    output logic                               oReady,
    input  logic [3:0]                         iOp,
    input  logic [((RV64 != 0) ? 64 : 32)-1:0] iS1,
    input  logic [((RV64 != 0) ? 64 : 32)-1:0] iS2,
    output logic                               oValid,
    input  logic                               iReady,
    output logic [((RV64 != 0) ? 64 : 32)-1:0] oRslt,
    output logic                               oErr
);

    localparam int CPU_WIDTH = (RV64 != 0) ? 64 : 32;
    localparam int NSTEP     = CPU_WIDTH / STEP;
    localparam int CW        = $clog2(CPU_WIDTH) + 1;

    localparam logic [1:0] K_CLZ  = 2'd0;
    localparam logic [1:0] K_CTZ  = 2'd1;
    localparam logic [1:0] K_CPOP = 2'd2;

    typedef enum logic {S_IDLE, S_COUNT} state_t;

    state_t               r_state;
    logic [CPU_WIDTH-1:0] r_shift;
    logic [CPU_WIDTH-1:0] r_rslt;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        r_idx;
    logic [1:0]           r_kind;
    logic                 r_valid;
    logic                 r_err;

    logic [STEP-1:0]      w_chunk;
    logic [CW-1:0]        w_lz;
    logic [CW-1:0]        w_tz;
    logic [CW-1:0]        w_pop;
    logic [CW-1:0]        w_add;
    logic [CW-1:0]        w_cnt_next;
    logic                 w_last;
    logic                 w_done;
    logic                 w_ready;
    logic                 w_is_logic;
    logic                 w_is_count;
    logic [CPU_WIDTH-1:0] w_logic;

    assign w_ready = (r_state == S_IDLE) && (!r_valid || iReady) && !iFlush;

    // CLZ walks the word from the top, CTZ and CPOP from the bottom.
    assign w_chunk = (r_kind == K_CLZ) ? r_shift[CPU_WIDTH-1 -: STEP] : r_shift[STEP-1:0];

    // Ascending scan: last set bit seen is the highest, giving leading zeros.
    // Descending scan: last set bit seen is the lowest, giving trailing zeros.
    always_comb begin
        w_lz  = CW'(STEP);
        w_tz  = CW'(STEP);
        w_pop = '0;
        for (int i = 0; i < STEP; i++) begin
            if (w_chunk[i]) begin
                w_lz  = CW'(STEP - 1 - i);
                w_pop = w_pop + CW'(1);
            end
        end
        for (int i = STEP - 1; i >= 0; i--) begin
            if (w_chunk[i]) begin
                w_tz = CW'(i);
            end
        end
    end

    always_comb begin
        case (r_kind)
            K_CLZ:   w_add = w_lz;
            K_CTZ:   w_add = w_tz;
            default: w_add = w_pop;
        endcase
    end

    assign w_cnt_next = r_cnt + w_add;
    assign w_last     = (r_idx == CW'(NSTEP - 1));
    // A non-zero chunk ends CLZ/CTZ early; CPOP always visits every chunk.
    assign w_done     = w_last || ((r_kind != K_CPOP) && (w_chunk != '0));

    assign w_is_logic = (iOp <= 4'd5);
    assign w_is_count = (iOp >= 4'd6) && (iOp <= 4'd8);

    always_comb begin
        case (iOp)
            4'd0:    w_logic = iS1 & iS2;
            4'd1:    w_logic = iS1 | iS2;
            4'd2:    w_logic = iS1 ^ iS2;
            4'd3:    w_logic = iS1 & ~iS2;
            4'd4:    w_logic = iS1 | ~iS2;
            4'd5:    w_logic = ~(iS1 ^ iS2);
            default: w_logic = '0;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_rslt  <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_kind  <= K_CLZ;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else if (iFlush) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
        end else begin
            if (r_valid && iReady) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (iValid && w_ready) begin
                        if (w_is_logic) begin
                            r_rslt  <= w_logic;
                            r_err   <= 1'b0;
                            r_valid <= 1'b1;
                        end else if (w_is_count) begin
                            r_shift <= iS1;
                            r_cnt   <= '0;
                            r_idx   <= '0;
                            r_kind  <= 2'(iOp - 4'd6);
                            r_state <= S_COUNT;
                        end else begin
                            r_rslt  <= '0;
                            r_err   <= 1'b1;
                            r_valid <= 1'b1;
                        end
                    end
                end
                S_COUNT: begin
                    r_cnt <= w_cnt_next;
                    r_idx <= r_idx + CW'(1);
                    if (r_kind == K_CLZ) begin
                        r_shift <= r_shift << STEP;
                    end else begin
                        r_shift <= r_shift >> STEP;
                    end
                    if (w_done) begin
                        r_rslt  <= {{(CPU_WIDTH - CW){1'b0}}, w_cnt_next};
                        r_err   <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign oReady = w_ready;
    assign oValid = r_valid;
    assign oRslt  = r_rslt;
    assign oErr   = r_err;

endmodule

// File: tb/tb_zion_riscv_bitops_exec_unit.sv
// tb/tb_zion_riscv_bitops_exec_unit.sv - scoreboard bench for zion_riscv_bitops_exec_unit

module tb_zion_riscv_bitops_exec_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush;
    logic        valid;
    logic        ready_o;
    logic [3:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic        ovalid;
    logic        iready;
    logic [31:0] rslt;
    logic        err;

    logic        w64_flush;
    logic        w64_valid;
    logic        w64_ready_o;
    logic [3:0]  w64_op;
    logic [63:0] w64_s1;
    logic [63:0] w64_s2;
    logic        w64_ovalid;
    logic        w64_iready;
    logic [63:0] w64_rslt;
    logic        w64_err;

    zion_riscv_bitops_exec_unit #(.RV64(0), .STEP(8)) dut (
        .iClk(clk), .iRst_n(rst_n), .iFlush(flush), .iValid(valid), .oReady(ready_o),
        .iOp(op), .iS1(s1), .iS2(s2), .oValid(ovalid), .iReady(iready),
        .oRslt(rslt), .oErr(err)
    );

    zion_riscv_bitops_exec_unit #(.RV64(1), .STEP(16)) dut64 (
        .iClk(clk), .iRst_n(rst_n), .iFlush(w64_flush), .iValid(w64_valid), .oReady(w64_ready_o),
        .iOp(w64_op), .iS1(w64_s1), .iS2(w64_s2), .oValid(w64_ovalid), .iReady(w64_iready),
        .oRslt(w64_rslt), .oErr(w64_err)
    );

    typedef struct {
        logic [63:0] rslt;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;

    function automatic logic [31:0] m_logic(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a ^ b;
            4'd3:    return a & ~b;
            4'd4:    return a | ~b;
            4'd5:    return ~(a ^ b);
            default: return 32'h0;
        endcase
    endfunction

    function automatic int m_clz(input logic [31:0] a);
        int n = 0;
        while (n < 32 && !a[31-n]) n++;
        return n;
    endfunction

    function automatic int m_ctz(input logic [31:0] a);
        int n = 0;
        while (n < 32 && !a[n]) n++;
        return n;
    endfunction

    // Cycles from accept edge to the cycle with oValid, for STEP=8 on 32 bits.
    function automatic int m_lat(input int c);
        return (c < 32) ? (c / 8 + 2) : 5;
    endfunction

    // Present one request, push its expectation, and return one cycle after the accept edge.
    task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] er, input logic ee, input int el);
        int t = 0;
        while (!ready_o && t < 100) begin
            @(posedge clk); #1; t++;
        end
        if (!ready_o) begin
            vectors++; miscompares++;
            $display("FAIL send_ready: oReady stayed %0b, required 1", ready_o);
        end
        op = o; s1 = a; s2 = b; valid = 1'b1;
        sb.push_back('{er, ee, el});
        @(posedge clk); #1;
        valid = 1'b0;
        op = 4'($urandom); s1 = $urandom; s2 = $urandom;
    endtask

    // Observe the next result; lat counts cycles after the accept edge.
    task automatic collect(output logic [63:0] r, output logic e, output int lat, output bit ok);
        lat = 1; ok = 1'b0; r = '0; e = 1'b0;
        while (lat <= 100) begin
            if (ovalid) begin
                ok = 1'b1; r = {32'h0, rslt}; e = err;
                break;
            end
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; valid = 1'b0; iready = 1'b1; op = 4'd0; s1 = '0; s2 = '0;
        w64_flush = 1'b0; w64_valid = 1'b0; w64_iready = 1'b1; w64_op = 4'd0; w64_s1 = '0; w64_s2 = '0;
        #3;
        vectors++;
        if (ovalid !== 1'b0 || rslt !== 32'h0 || err !== 1'b0 || ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset: oValid=%0b oRslt=%h oErr=%0b oReady=%0b, required 0 0 0 1", ovalid, rslt, err, ready_o);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_logic_ops();
        logic [3:0]  t_op [6] = '{4'd0, 4'd3, 4'd5, 4'd1, 4'd2, 4'd4};
        logic [31:0] t_a  [6] = '{32'hF0F0_00FF, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 32'hF0F0_00FF, 32'hF0F0_00FF, 32'h1234_0000};
        logic [31:0] t_b  [6] = '{32'h0FF0_0F0F, 32'h0000_FFFF, 32'h5A5A_5A5A, 32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'hFFFF_0000};
        logic [31:0] t_e  [6] = '{32'h00F0_000F, 32'hFFFF_0000, 32'h0000_0000, 32'hFFF0_0FFF, 32'hFF00_0FF0, 32'h1234_FFFF};
        logic [63:0] r; logic e; int lat; bit ok; exp_t x;
        for (int i = 0; i < 12; i++) begin
            logic [3:0] o; logic [31:0] a, b, ex;
            if (i < 6) begin
                o = t_op[i]; a = t_a[i]; b = t_b[i]; ex = t_e[i];
            end else begin
                o = 4'(i - 6); a = $urandom; b = $urandom; ex = m_logic(o, a, b);
            end
            send(o, a, b, {32'h0, ex}, 1'b0, 1);
            collect(r, e, lat, ok);
            x = sb.pop_front();
            vectors++;
            if (!ok || r !== x.rslt || e !== x.err || lat !== x.lat) begin
                miscompares++;
                $display("FAIL logic_op%0d: rslt=%h err=%0b lat=%0d ok=%0b, required rslt=%h err=%0b lat=%0d",
                         o, r, e, lat, ok, x.rslt, x.err, x.lat);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_count_ops();
        logic [3:0]  t_op [4] = '{4'd6, 4'd6, 4'd7, 4'd8};
        logic [31:0] t_a  [4] = '{32'h0001_0000, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF};
        int          t_e  [4] = '{15, 32, 31, 32};
        int          t_l  [4] = '{3, 5, 5, 5};
        logic [63:0] r; logic e; int lat; bit ok; exp_t x;
        for (int i = 0; i < 13; i++) begin
            logic [3:0] o; logic [31:0] a; int c, l;
            if (i < 4) begin
                o = t_op[i]; a = t_a[i]; c = t_e[i]; l = t_l[i];
            end else begin
                o = 4'(6 + (i % 3));
                a = $urandom;
                if (o == 4'd6) a = a >> $urandom_range(0, 31);
                if (o == 4'd7) a = a << $urandom_range(0, 31);
                c = (o == 4'd6) ? m_clz(a) : (o == 4'd7) ? m_ctz(a) : $countones(a);
                l = (o == 4'd8) ? 5 : m_lat(c);
            end
            send(o, a, $urandom, 64'(c), 1'b0, l);
            collect(r, e, lat, ok);
            x = sb.pop_front();
            vectors++;
            if (!ok || r !== x.rslt || e !== x.err || lat !== x.lat) begin
                miscompares++;
                $display("FAIL count_op%0d src=%h: rslt=%0d err=%0b lat=%0d ok=%0b, required rslt=%0d err=%0b lat=%0d",
                         o, a, r, e, lat, ok, x.rslt, x.err, x.lat);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        logic [63:0] r; logic e; int lat; bit ok; exp_t x;
        for (int i = 9; i < 16; i += 3) begin
            send(4'(i), 32'hDEAD_BEEF, 32'h1234_5678, 64'h0, 1'b1, 1);
            collect(r, e, lat, ok);
            x = sb.pop_front();
            vectors++;
            if (!ok || r !== x.rslt || e !== x.err || lat !== x.lat) begin
                miscompares++;
                $display("FAIL illegal_op%0d: rslt=%h err=%0b lat=%0d, required rslt=%h err=%0b lat=%0d",
                         i, r, e, lat, x.rslt, x.err, x.lat);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] r; logic e; int lat; bit ok; exp_t x; bit held;
        iready = 1'b0;
        send(4'd0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 64'h00F0_000F, 1'b0, 1);
        collect(r, e, lat, ok);
        held = ok;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (!ovalid || rslt !== 32'h00F0_000F || ready_o !== 1'b0) held = 1'b0;
        end
        x = sb.pop_front();
        vectors++;
        if (!held || rslt !== x.rslt[31:0] || err !== x.err) begin
            miscompares++;
            $display("FAIL hold: oValid=%0b oRslt=%h oReady=%0b, required 1 %h 0", ovalid, rslt, ready_o, x.rslt[31:0]);
        end
        op = 4'd1; s1 = 32'h1111_0000; s2 = 32'h0000_2222; valid = 1'b1; iready = 1'b1;
        sb.push_back('{64'h1111_2222, 1'b0, 1});
        #1;
        vectors++;
        if (ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL release_ready: oReady=%0b, required 1", ready_o);
        end
        @(posedge clk); #1;
        valid = 1'b0;
        x = sb.pop_front();
        vectors++;
        if (ovalid !== 1'b1 || {32'h0, rslt} !== x.rslt || err !== x.err) begin
            miscompares++;
            $display("FAIL release_next: oValid=%0b oRslt=%h, required 1 %h", ovalid, rslt, x.rslt[31:0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        exp_t x;
        valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            op = 4'(i); s1 = $urandom; s2 = $urandom;
            sb.push_back('{{32'h0, m_logic(op, s1, s2)}, 1'b0, 1});
            #1;
            vectors++;
            if (ready_o !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_ready%0d: oReady=%0b, required 1", i, ready_o);
            end
            @(posedge clk); #1;
            x = sb.pop_front();
            vectors++;
            if (ovalid !== 1'b1 || {32'h0, rslt} !== x.rslt || err !== x.err) begin
                miscompares++;
                $display("FAIL b2b%0d: oValid=%0b oRslt=%h, required 1 %h", i, ovalid, rslt, x.rslt[31:0]);
            end
        end
        valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        bit quiet = 1'b1;
        send(4'd6, 32'h0, 32'h0, 64'd32, 1'b0, 5);
        void'(sb.pop_back());
        @(posedge clk); #1;
        flush = 1'b1;
        #1;
        vectors++;
        if (ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_ready_low: oReady=%0b, required 0", ready_o);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        vectors++;
        if (ready_o !== 1'b1 || ovalid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_idle: oReady=%0b oValid=%0b, required 1 0", ready_o, ovalid);
        end
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (ovalid) quiet = 1'b0;
        end
        vectors++;
        if (!quiet) begin
            miscompares++;
            $display("FAIL flush_discard: oValid seen=1, required 0");
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] r; logic e; int lat; bit ok; exp_t x; bit quiet = 1'b1;
        send(4'd5, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 64'hFFFF_FFFF, 1'b0, 1);
        collect(r, e, lat, ok);
        x = sb.pop_front();
        @(posedge clk); #1;
        send(4'd6, 32'h0, 32'h0, 64'd32, 1'b0, 5);
        void'(sb.pop_back());
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (ovalid !== 1'b0 || rslt !== 32'h0 || ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid: oValid=%0b oRslt=%h oReady=%0b, required 0 0 1", ovalid, rslt, ready_o);
        end
        #1 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (ovalid) quiet = 1'b0;
        end
        vectors++;
        if (!quiet) begin
            miscompares++;
            $display("FAIL reset_mid_discard: oValid seen=1, required 0");
        end
        send(4'd2, 32'hFF00_FF00, 32'h0F0F_0F0F, 64'hF00F_F00F, 1'b0, 1);
        collect(r, e, lat, ok);
        x = sb.pop_front();
        vectors++;
        if (!ok || r !== x.rslt || lat !== x.lat) begin
            miscompares++;
            $display("FAIL reset_recover: rslt=%h lat=%0d, required %h %0d", r, lat, x.rslt, x.lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rv64();
        logic [3:0]  t_op [2] = '{4'd8, 4'd6};
        logic [63:0] t_a  [2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1};
        logic [63:0] t_e  [2] = '{64'd64, 64'd63};
        exp_t x;
        for (int i = 0; i < 2; i++) begin
            int lat = 1;
            w64_op = t_op[i]; w64_s1 = t_a[i]; w64_s2 = '0; w64_valid = 1'b1;
            sb.push_back('{t_e[i], 1'b0, 5});
            @(posedge clk); #1;
            w64_valid = 1'b0;
            while (!w64_ovalid && lat < 100) begin
                @(posedge clk); #1; lat++;
            end
            x = sb.pop_front();
            vectors++;
            if (!w64_ovalid || w64_rslt !== x.rslt || w64_err !== x.err || lat !== x.lat) begin
                miscompares++;
                $display("FAIL rv64_op%0d: oValid=%0b rslt=%0d lat=%0d, required 1 %0d %0d",
                         t_op[i], w64_ovalid, w64_rslt, lat, x.rslt, x.lat);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_logic_ops();
        test_count_ops();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_rv64();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
